char_pack_compressor: RTL

CHAR_PACK_COMPRESSOR -- requirements
Module: char_pack_compressor

---
 rtl/char_pack_compressor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/char_pack_compressor.sv
// ---------------------------------------------------------------------------
// char_pack_compressor
//
// Maps 8-bit extended-ASCII characters to 7-bit codes and packs
// CODES_PER_WORD codes into one output word. Slot k sits at bits
// [7k+6:7k], and slot 0 holds the first character accepted.
// A word is emitted when it fills, or when FLUSH is accepted while a
// partial word is held. In a partial word, the unused slots are zero.
//
// Parameters
//   CODES_PER_WORD : number of 7-bit codes per output word (1..8)
//   DROP_INVALID   : 0 = an unmappable character becomes code 0,
//                    1 = an unmappable character is discarded
//
// Optional feature (macro COMPRESS_STATS_EN)
//   Adds output DROP_CNT. It is a 16-bit saturating count of accepted
//   unmappable characters.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   IN_DATA   in   [7:0] character
//   IN_VALID  in   IN_DATA valid
//   IN_READY  out  character / FLUSH accepted this cycle
//   FLUSH     in   emit the partial word
//   OUT_DATA  out  [7*CODES_PER_WORD-1:0] packed codes
//   OUT_COUNT out  number of valid slots in OUT_DATA
//   OUT_VALID out  OUT_DATA / OUT_COUNT valid
//   OUT_READY in   downstream takes the word
//   DROP_CNT  out  [15:0] unmappable count (COMPRESS_STATS_EN only)
// ---------------------------------------------------------------------------
module char_pack_compressor #(
    parameter int CODES_PER_WORD = 4,
    parameter int DROP_INVALID   = 0
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [7:0]                              IN_DATA,
    input  logic                                    IN_VALID,
    output logic                                    IN_READY,
    input  logic                                    FLUSH,
    output logic [7*CODES_PER_WORD-1:0]             OUT_DATA,
    output logic [$clog2(CODES_PER_WORD+1)-1:0]     OUT_COUNT,
    output logic                                    OUT_VALID,
`ifdef COMPRESS_STATS_EN
    output logic [15:0]                             DROP_CNT,
`endif
    input  logic                                    OUT_READY
);

    localparam int OUT_W = 7 * CODES_PER_WORD;
    localparam int CNT_W = $clog2(CODES_PER_WORD + 1);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic               flush_ok;
    logic [7:0]         mapped;
    logic               unmappable;
    logic [6:0]         code;
    logic               advance;
    logic [OUT_W-1:0]   acc_fill;
    logic [CNT_W-1:0]   cnt_fill;
    logic               word_done;
    logic               emit;

    // Returns {unmappable, code}. The special-case characters are
    // checked before the range test.
    function automatic logic [7:0] map_char(input logic [7:0] c);
        logic [7:0] off;
        off = c - 8'd32;
        case (c)
            8'd162:  map_char = {1'b0, 7'd95};
            8'd163:  map_char = {1'b0, 7'd97};
            8'd165:  map_char = {1'b0, 7'd109};
            8'd169:  map_char = {1'b0, 7'd111};
            8'd174:  map_char = {1'b0, 7'd112};
            8'd176:  map_char = {1'b0, 7'd125};
            default: begin
                if (c < 8'd32 || c > 8'd159) begin
                    map_char = 8'h80;
                end else begin
                    map_char = {1'b0, off[6:0]};
                end
            end
        endcase
    endfunction

    always_comb begin
        // The output register can take a new word if it is empty or
        // if its word is being consumed on this edge.
        in_ready   = !(out_valid_q && !OUT_READY);
        accept     = IN_VALID && in_ready;
        flush_ok   = FLUSH && in_ready;
        mapped     = map_char(IN_DATA);
        unmappable = mapped[7];
        code       = mapped[6:0];
        advance    = accept && !((DROP_INVALID != 0) && unmappable);

        acc_fill = acc_q;
        if (advance) begin
            for (int k = 0; k < CODES_PER_WORD; k++) begin
                if (CNT_W'(k) == cnt_q) begin
                    acc_fill[7*k +: 7] = code;
                end
            end
        end
        cnt_fill = cnt_q + CNT_W'(advance);

        // A char that completes the word already forms the emitted
        // word, so a FLUSH on the same cycle adds no extra empty word.
        word_done = (cnt_fill == CNT_W'(CODES_PER_WORD));
        emit      = word_done || (flush_ok && (cnt_fill != '0));

        acc_d       = acc_fill;
        cnt_d       = cnt_fill;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q && !OUT_READY;

        if (emit) begin
            out_data_d  = acc_fill;
            out_count_d = cnt_fill;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
        end

        state_d = state_q;
        case (state_q)
            ST_EMPTY:   if (cnt_d != '0) state_d = ST_FILLING;
            ST_FILLING: if (cnt_d == '0) state_d = ST_EMPTY;
            default:    state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_DATA  = out_data_q;
    assign OUT_COUNT = out_count_q;
    assign OUT_VALID = out_valid_q;

`ifdef COMPRESS_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && unmappable && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

endmodule
